dmem_mmio_responder: RTL and testbench



---
 rtl/dmem_mmio_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Data-memory responder for the single-cycle MIPS core. It holds a
//   word-organised RAM with byte-lane writes and a 256-byte MMIO window.
//   The window contains a free-running cycle counter, a compare timer with a
//   sticky pending flag, and a read-only ID word.
//
//   Reads are combinational from dmem_addr. Writes commit on posedge clk.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   dmem_addr  byte address from the core, presented every cycle
//   dmem_din   write data
//   dmem_be    byte enables; bit i selects lane [8i+7:8i]
//   dmem_wren  write strobe
//   dmem_dout  combinational read data
//   err        sticky write-error flag, cleared only by rst
//   tmr_irq    timer pending flag
//
// MMIO map (offset from MMIO_BASE)
//   0x00 CYCLE    RO
//   0x04 TMR_CMP  RW
//   0x08 TMR_CTRL RW  bit0 enable, bit1 pending (write-1-to-clear)
//   0x0C ID       RO
//   0x10 TMR_CNT  RW
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00,
    parameter logic [31:0] ID_VALUE    = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_din,
    input  logic [3:0]  dmem_be,
    input  logic        dmem_wren,
    output logic [31:0] dmem_dout,
    output logic        err,
    output logic        tmr_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [5:0] OFS_CYCLE = 6'h00;
    localparam logic [5:0] OFS_CMP   = 6'h01;
    localparam logic [5:0] OFS_CTRL  = 6'h02;
    localparam logic [5:0] OFS_ID    = 6'h03;
    localparam logic [5:0] OFS_CNT   = 6'h04;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] cycle_q;
    logic [31:0] tmr_cnt_q;
    logic [31:0] tmr_cmp_q;
    logic        tmr_en_q;
    logic        tmr_pend_q;
    logic        err_q;

    // Address decode. The MMIO window takes priority over the RAM range.
    logic          mmio_hit;
    logic          ram_hit;
    logic          unmapped;
    logic          aligned;
    logic [AW-1:0] ram_idx;
    logic [5:0]    mmio_ofs;

    assign mmio_hit = (dmem_addr[31:8] == MMIO_BASE[31:8]);
    assign ram_hit  = !mmio_hit && ({1'b0, dmem_addr} < RAM_LIMIT);
    assign unmapped = !mmio_hit && !ram_hit;
    assign aligned  = (dmem_addr[1:0] == 2'b00);
    assign ram_idx  = dmem_addr[AW+1:2];
    assign mmio_ofs = dmem_addr[7:2];

    logic ram_wr;
    logic mmio_wr;
    logic wr_fault;

    assign ram_wr   = dmem_wren && ram_hit && aligned;
    assign mmio_wr  = dmem_wren && mmio_hit && aligned && (dmem_be == 4'hF);
    assign wr_fault = dmem_wren && (unmapped
                                    || (ram_hit && !aligned)
                                    || (mmio_hit && !(aligned && (dmem_be == 4'hF))));

    logic wr_cmp;
    logic wr_ctrl;
    logic wr_cnt;

    assign wr_cmp  = mmio_wr && (mmio_ofs == OFS_CMP)  && (dmem_addr[7:6] == 2'b00);
    assign wr_ctrl = mmio_wr && (mmio_ofs == OFS_CTRL) && (dmem_addr[7:6] == 2'b00);
    assign wr_cnt  = mmio_wr && (mmio_ofs == OFS_CNT)  && (dmem_addr[7:6] == 2'b00);

    // The match uses the pre-write counter, so a core write to TMR_CNT in the
    // same cycle can still raise pending.
    logic tmr_match;
    assign tmr_match = tmr_en_q && (tmr_cnt_q == tmr_cmp_q);

    // RAM is never reset. A write in the reset cycle is still discarded.
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= dmem_din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q    <= 32'd0;
            tmr_cnt_q  <= 32'd0;
            tmr_cmp_q  <= 32'd0;
            tmr_en_q   <= 1'b0;
            tmr_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;

            if (wr_cnt) begin
                tmr_cnt_q <= dmem_din;
            end else if (tmr_match) begin
                tmr_cnt_q <= 32'd0;
            end else if (tmr_en_q) begin
                tmr_cnt_q <= tmr_cnt_q + 32'd1;
            end

            if (wr_cmp) begin
                tmr_cmp_q <= dmem_din;
            end

            if (wr_ctrl) begin
                tmr_en_q <= dmem_din[0];
            end

            // A set from a match wins over a same-cycle clear.
            if (tmr_match) begin
                tmr_pend_q <= 1'b1;
            end else if (wr_ctrl && dmem_din[1]) begin
                tmr_pend_q <= 1'b0;
            end

            if (wr_fault) begin
                err_q <= 1'b1;
            end
        end
    end

    // Read mux. Undefined MMIO offsets and unmapped addresses return 0.
    always_comb begin
        dmem_dout = 32'd0;
        if (mmio_hit) begin
            if (dmem_addr[7:6] == 2'b00) begin
                case (mmio_ofs)
                    OFS_CYCLE: dmem_dout = cycle_q;
                    OFS_CMP:   dmem_dout = tmr_cmp_q;
                    OFS_CTRL:  dmem_dout = {30'd0, tmr_pend_q, tmr_en_q};
                    OFS_ID:    dmem_dout = ID_VALUE;
                    OFS_CNT:   dmem_dout = tmr_cnt_q;
                    default:   dmem_dout = 32'd0;
                endcase
            end
        end else if (ram_hit) begin
            dmem_dout = mem[ram_idx];
        end
    end

    assign err     = err_q;
    assign tmr_irq = tmr_pend_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    localparam logic [31:0] MB     = 32'h0000_7F00;
    localparam logic [31:0] A_CYC  = MB + 32'h00;
    localparam logic [31:0] A_CMP  = MB + 32'h04;
    localparam logic [31:0] A_CTRL = MB + 32'h08;
    localparam logic [31:0] A_ID   = MB + 32'h0C;
    localparam logic [31:0] A_CNT  = MB + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [3:0]  dmem_be;
    logic        dmem_wren;
    logic [31:0] dmem_dout;
    logic        err;
    logic        tmr_irq;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_mmio_responder #(
        .DEPTH_WORDS(1024),
        .MMIO_BASE  (32'h0000_7F00),
        .ID_VALUE   (32'h4D49_5053)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dmem_addr(dmem_addr),
        .dmem_din (dmem_din),
        .dmem_be  (dmem_be),
        .dmem_wren(dmem_wren),
        .dmem_dout(dmem_dout),
        .err      (err),
        .tmr_irq  (tmr_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One write cycle; returns 1 time unit after the committing edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dmem_addr = a;
        dmem_din  = d;
        dmem_be   = be;
        dmem_wren = 1'b1;
        @(posedge clk);
        #1;
        dmem_wren = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dmem_wren = 1'b0;
        dmem_addr = a;
        #1;
        chk(tag, dmem_dout, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        dmem_wren = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        dmem_addr = 32'd0;
        dmem_din  = 32'd0;
        dmem_be   = 4'h0;
        dmem_wren = 1'b0;
        tick();
        tick();

        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_irq", {31'd0, tmr_irq}, 32'd0);
        rd("rst_cycle", A_CYC, 32'd0);
        rd("rst_cnt",   A_CNT, 32'd0);
        rd("rst_cmp",   A_CMP, 32'd0);
        rd("rst_ctrl",  A_CTRL, 32'd0);
        rst = 1'b0;

        // CYCLE and ID
        repeat (10) @(posedge clk);
        #1;
        rd("cycle_10", A_CYC, 32'd10);
        rd("id", A_ID, 32'h4D49_5053);
        wr(A_CYC, 32'h1234_5678, 4'hF);
        rd("cycle_ro", A_CYC, 32'd11);
        wr(A_ID, 32'h0, 4'hF);
        rd("id_ro", A_ID, 32'h4D49_5053);
        wr(MB + 32'h20, 32'hFFFF_FFFF, 4'hF);
        rd("undef_ofs", MB + 32'h20, 32'd0);
        chk("ro_no_err", {31'd0, err}, 32'd0);

        // RAM byte lanes and read-during-write
        wr(32'h40, 32'h1122_3344, 4'hF);
        rd("ram_full", 32'h40, 32'h1122_3344);
        dmem_addr = 32'h40;
        dmem_din  = 32'hAABB_CCDD;
        dmem_be   = 4'b0101;
        dmem_wren = 1'b1;
        #1;
        chk("ram_rdw_old", dmem_dout, 32'h1122_3344);
        @(posedge clk);
        #1;
        dmem_wren = 1'b0;
        rd("ram_lanes", 32'h40, 32'h11BB_33DD);
        wr(32'h40, 32'h0, 4'h0);
        rd("ram_be0", 32'h40, 32'h11BB_33DD);
        rd("ram_lowbits", 32'h43, 32'h11BB_33DD);
        rd("unmapped_rd", 32'h0001_0000, 32'd0);
        chk("rd_no_err", {31'd0, err}, 32'd0);

        // Timer 0,1,2,3,0
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        rd("tmr_c0", A_CNT, 32'd0);
        tick(); chk("tmr_c1", dmem_dout, 32'd1);
        tick(); chk("tmr_c2", dmem_dout, 32'd2);
        tick(); chk("tmr_c3", dmem_dout, 32'd3);
        chk("tmr_irq_pre", {31'd0, tmr_irq}, 32'd0);
        tick(); chk("tmr_wrap", dmem_dout, 32'd0);
        chk("tmr_irq_set", {31'd0, tmr_irq}, 32'd1);
        wr(A_CTRL, 32'd2, 4'hF);
        chk("tmr_w1c", {31'd0, tmr_irq}, 32'd0);
        rd("tmr_after_w1c", A_CNT, 32'd1);
        tick(); chk("tmr_hold", dmem_dout, 32'd1);
        rd("ctrl_off", A_CTRL, 32'd0);

        // W1C coinciding with a match
        wr(A_CMP, 32'd0, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        chk("cmp0_irq", {31'd0, tmr_irq}, 32'd1);
        wr(A_CTRL, 32'd3, 4'hF);
        chk("w1c_vs_match", {31'd0, tmr_irq}, 32'd1);
        rd("ctrl_3", A_CTRL, 32'd3);
        wr(A_CNT, 32'd5, 4'hF);
        rd("cnt_wr_wins", A_CNT, 32'd5);
        wr(A_CTRL, 32'd2, 4'hF);
        chk("tmr_stop_irq", {31'd0, tmr_irq}, 32'd0);

        // MMIO byte-enable violation
        wr(A_CMP, 32'h77, 4'b0011);
        rd("mmio_be_cmp", A_CMP, 32'd0);
        chk("mmio_be_err", {31'd0, err}, 32'd1);

        // Misaligned RAM write
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);
        wr(32'h42, 32'hDEAD_BEEF, 4'hF);
        chk("misalign_err", {31'd0, err}, 32'd1);
        rd("misalign_ram", 32'h40, 32'h11BB_33DD);

        // Write just past RAM
        do_reset();
        wr(32'h0000_1000, 32'h1, 4'hF);
        chk("oob_err", {31'd0, err}, 32'd1);

        // Reset mid-run
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        chk("pre_rst_irq", {31'd0, tmr_irq}, 32'd1);
        rst       = 1'b1;
        dmem_addr = 32'h40;
        dmem_din  = 32'hCAFE_F00D;
        dmem_be   = 4'hF;
        dmem_wren = 1'b1;
        tick();
        rst       = 1'b0;
        dmem_wren = 1'b0;
        chk("mid_rst_irq", {31'd0, tmr_irq}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        rd("mid_rst_cycle", A_CYC, 32'd0);
        rd("mid_rst_cnt",   A_CNT, 32'd0);
        rd("mid_rst_cmp",   A_CMP, 32'd0);
        rd("mid_rst_ctrl",  A_CTRL, 32'd0);
        rd("mid_rst_ram",   32'h40, 32'h11BB_33DD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
